// File: rtl/ciq_pkg.sv
// Shared defaults, entry layout and constants for the central issue queue.
// Entry fields are sized from the *_DEF widths; override those here rather than only at the top.
package ciq_pkg;

   localparam int ISSUE_NUM_DEF     = 4;
   localparam int PRF_WIDTH_DEF     = 6;
   localparam int CIQ_DEPTH_DEF     = 16;
   localparam int PAYLOAD_WIDTH_DEF = 32;

   localparam logic [PRF_WIDTH_DEF-1:0] PRF_ZERO = '0;

   typedef struct packed {
      logic                         valid;
      logic [PRF_WIDTH_DEF-1:0]     prs1;
      logic                         r1;
      logic [PRF_WIDTH_DEF-1:0]     prs2;
      logic                         r2;
      logic [PRF_WIDTH_DEF-1:0]     prd;
      logic                         prd_v;
      logic [PAYLOAD_WIDTH_DEF-1:0] payload;
   } ciq_entry_t;

endpackage

// File: rtl/ciq_select.sv
// Multi-port fixed-priority picker: port k grants the lowest candidate not taken by ports below it.
// Purely combinational; a port with iss_ready low grants nothing and leaves its candidate for higher ports.
module ciq_select
   import ciq_pkg::*;
#(
   parameter int ISSUE_NUM = ISSUE_NUM_DEF,
   parameter int CIQ_DEPTH = CIQ_DEPTH_DEF
)(
   input  logic [CIQ_DEPTH-1:0]                cand,
   input  logic [ISSUE_NUM-1:0]                iss_ready,
   output logic [ISSUE_NUM-1:0][CIQ_DEPTH-1:0] grant,
   output logic [ISSUE_NUM-1:0]                grant_valid
);

   always_comb begin : pick
      logic [CIQ_DEPTH-1:0] left;
      logic                 found;
      left        = cand;
      found       = 1'b0;
      grant       = '0;
      grant_valid = '0;
      for (int k = 0; k < ISSUE_NUM; k++) begin
         found = 1'b0;
         if (iss_ready[k]) begin
            for (int i = 0; i < CIQ_DEPTH; i++) begin
               if (left[i] && !found) begin
                  grant[k][i]    = 1'b1;
                  grant_valid[k] = 1'b1;
                  found          = 1'b1;
               end
            end
         end
         left = left & ~grant[k];
      end
   end

endmodule

// File: rtl/ciq_issue_queue.sv
// Central issue queue: holds dispatched ops until both sources are ready, issues up to ISSUE_NUM per cycle, 1-cycle ready-to-issue.
// Dispatch is refused when full (disp_ready from registered count); CIQ_PERF_CNT_EN adds full-stall and issued-op counters.
module ciq_issue_queue
   import ciq_pkg::*;
#(
   parameter int ISSUE_NUM     = ISSUE_NUM_DEF,
   parameter int PRF_WIDTH     = PRF_WIDTH_DEF,
   parameter int CIQ_DEPTH     = CIQ_DEPTH_DEF,
   parameter int PAYLOAD_WIDTH = PAYLOAD_WIDTH_DEF,
   localparam int CNT_W        = $clog2(CIQ_DEPTH) + 1,
   localparam int IDX_W        = $clog2(CIQ_DEPTH)
)(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               flush,
   input  logic                               disp_valid,
   output logic                               disp_ready,
   input  logic [PRF_WIDTH-1:0]               disp_prs1,
   input  logic                               disp_prs1_rdy,
   input  logic [PRF_WIDTH-1:0]               disp_prs2,
   input  logic                               disp_prs2_rdy,
   input  logic [PRF_WIDTH-1:0]               disp_prd,
   input  logic                               disp_prd_v,
   input  logic [PAYLOAD_WIDTH-1:0]           disp_payload,
   input  logic [ISSUE_NUM-1:0]               wake_v,
   input  logic [ISSUE_NUM*PRF_WIDTH-1:0]     wake_tag,
   input  logic [ISSUE_NUM-1:0]               iss_ready,
   output logic [ISSUE_NUM-1:0]               iss_valid,
   output logic [ISSUE_NUM*PRF_WIDTH-1:0]     iss_prd,
   output logic [ISSUE_NUM-1:0]               iss_prd_v,
   output logic [ISSUE_NUM*PAYLOAD_WIDTH-1:0] iss_payload,
   output logic [CNT_W-1:0]                   count
`ifdef CIQ_PERF_CNT_EN
   ,
   output logic [31:0]                        perf_full_cycles,
   output logic [31:0]                        perf_issued
`endif
);

   ciq_entry_t                         ent [CIQ_DEPTH];
   ciq_entry_t                         new_ent;
   logic [CIQ_DEPTH-1:0]               cand;
   logic [CIQ_DEPTH-1:0]               granted_mask;
   logic [ISSUE_NUM-1:0][CIQ_DEPTH-1:0] grant;
   logic [ISSUE_NUM-1:0]               grant_valid;
   logic [CNT_W-1:0]                   grant_cnt;
   logic [IDX_W-1:0]                   free_idx;
   logic                               disp_fire;
   logic [PRF_WIDTH-1:0]               sel_prd     [ISSUE_NUM];
   logic                               sel_prd_v   [ISSUE_NUM];
   logic [PAYLOAD_WIDTH-1:0]           sel_payload [ISSUE_NUM];

   function automatic logic tag_hit(input logic [PRF_WIDTH-1:0]           tag,
                                    input logic [ISSUE_NUM-1:0]           v,
                                    input logic [ISSUE_NUM*PRF_WIDTH-1:0] tags);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < ISSUE_NUM; k++)
         if (v[k] && tags[k*PRF_WIDTH +: PRF_WIDTH] == tag) hit = 1'b1;
      return hit;
   endfunction

   assign disp_ready = (count != CNT_W'(CIQ_DEPTH));
   assign disp_fire  = disp_valid && disp_ready;

   always_comb begin
      for (int i = 0; i < CIQ_DEPTH; i++)
         cand[i] = ent[i].valid & ent[i].r1 & ent[i].r2;
   end

   // count tracks occupancy, so a free slot always exists whenever disp_ready is high
   always_comb begin : find_free
      logic found;
      found    = 1'b0;
      free_idx = '0;
      for (int i = 0; i < CIQ_DEPTH; i++) begin
         if (!ent[i].valid && !found) begin
            free_idx = IDX_W'(i);
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.prs1    = disp_prs1;
      new_ent.r1      = disp_prs1_rdy || (disp_prs1 == PRF_ZERO) || tag_hit(disp_prs1, wake_v, wake_tag);
      new_ent.prs2    = disp_prs2;
      new_ent.r2      = disp_prs2_rdy || (disp_prs2 == PRF_ZERO) || tag_hit(disp_prs2, wake_v, wake_tag);
      new_ent.prd     = disp_prd;
      new_ent.prd_v   = disp_prd_v;
      new_ent.payload = disp_payload;
   end

   ciq_select #(
      .ISSUE_NUM   (ISSUE_NUM),
      .CIQ_DEPTH   (CIQ_DEPTH)
   ) u_select (
      .cand        (cand),
      .iss_ready   (iss_ready),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   always_comb begin
      granted_mask = '0;
      grant_cnt    = '0;
      for (int k = 0; k < ISSUE_NUM; k++) begin
         granted_mask = granted_mask | grant[k];
         grant_cnt    = grant_cnt + CNT_W'(grant_valid[k]);
      end
   end

   // grants are one-hot per port, so an OR-reduction is a sufficient mux
   always_comb begin
      for (int k = 0; k < ISSUE_NUM; k++) begin
         sel_prd[k]     = '0;
         sel_prd_v[k]   = 1'b0;
         sel_payload[k] = '0;
         for (int i = 0; i < CIQ_DEPTH; i++) begin
            if (grant[k][i]) begin
               sel_prd[k]     = sel_prd[k]     | ent[i].prd;
               sel_prd_v[k]   = sel_prd_v[k]   | ent[i].prd_v;
               sel_payload[k] = sel_payload[k] | ent[i].payload;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CIQ_DEPTH; i++) ent[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < CIQ_DEPTH; i++) ent[i].valid <= 1'b0;
      end else begin
         for (int i = 0; i < CIQ_DEPTH; i++) begin
            if (granted_mask[i]) begin
               ent[i].valid <= 1'b0;
            end else if (ent[i].valid) begin
               ent[i].r1 <= ent[i].r1 | tag_hit(ent[i].prs1, wake_v, wake_tag);
               ent[i].r2 <= ent[i].r2 | tag_hit(ent[i].prs2, wake_v, wake_tag);
            end else if (disp_fire && free_idx == IDX_W'(i)) begin
               ent[i] <= new_ent;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      count <= '0;
      else if (flush)  count <= '0;
      else             count <= count + CNT_W'(disp_fire) - grant_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iss_valid   <= '0;
         iss_prd     <= '0;
         iss_prd_v   <= '0;
         iss_payload <= '0;
      end else if (flush) begin
         iss_valid   <= '0;
      end else begin
         iss_valid   <= grant_valid;
         for (int k = 0; k < ISSUE_NUM; k++) begin
            if (grant_valid[k]) begin
               iss_prd[k*PRF_WIDTH +: PRF_WIDTH]             <= sel_prd[k];
               iss_prd_v[k]                                  <= sel_prd_v[k];
               iss_payload[k*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] <= sel_payload[k];
            end
         end
      end
   end

`ifdef CIQ_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_full_cycles <= '0;
         perf_issued      <= '0;
      end else begin
         if (disp_valid && !disp_ready) perf_full_cycles <= perf_full_cycles + 32'd1;
         if (!flush)                    perf_issued      <= perf_issued + 32'(grant_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_ciq_issue_queue.sv
// Directed test-plan steps followed by a random phase, all checked against an entry-array reference model.
module tb_ciq_issue_queue;

   localparam int N = 4;
   localparam int W = 6;
   localparam int D = 16;
   localparam int P = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           flush;
   logic           disp_valid;
   logic           disp_ready;
   logic [W-1:0]   disp_prs1, disp_prs2, disp_prd;
   logic           disp_prs1_rdy, disp_prs2_rdy, disp_prd_v;
   logic [P-1:0]   disp_payload;
   logic [N-1:0]   wake_v;
   logic [N*W-1:0] wake_tag;
   logic [N-1:0]   iss_ready;
   logic [N-1:0]   iss_valid;
   logic [N*W-1:0] iss_prd;
   logic [N-1:0]   iss_prd_v;
   logic [N*P-1:0] iss_payload;
   logic [4:0]     count;

   int n_cmp  = 0;
   int n_fail = 0;

   // reference model: entry array plus expected issue registers
   bit           m_v   [D];
   bit           m_r1  [D];
   bit           m_r2  [D];
   bit           m_pdv [D];
   logic [W-1:0] m_p1  [D];
   logic [W-1:0] m_p2  [D];
   logic [W-1:0] m_pd  [D];
   logic [P-1:0] m_pl  [D];
   logic [N-1:0] exp_iv;
   logic [W-1:0] exp_prd  [N];
   logic         exp_prdv [N];
   logic [P-1:0] exp_pl   [N];

   ciq_issue_queue dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .disp_valid    (disp_valid),
      .disp_ready    (disp_ready),
      .disp_prs1     (disp_prs1),
      .disp_prs1_rdy (disp_prs1_rdy),
      .disp_prs2     (disp_prs2),
      .disp_prs2_rdy (disp_prs2_rdy),
      .disp_prd      (disp_prd),
      .disp_prd_v    (disp_prd_v),
      .disp_payload  (disp_payload),
      .wake_v        (wake_v),
      .wake_tag      (wake_tag),
      .iss_ready     (iss_ready),
      .iss_valid     (iss_valid),
      .iss_prd       (iss_prd),
      .iss_prd_v     (iss_prd_v),
      .iss_payload   (iss_payload),
      .count         (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < D; i++) c += m_v[i];
      return c;
   endfunction

   function automatic bit hit(input logic [W-1:0] t);
      bit h = 0;
      for (int k = 0; k < N; k++)
         if (wake_v[k] && wake_tag[k*W +: W] == t) h = 1;
      return h;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < D; i++) m_v[i] = 0;
      exp_iv = '0;
   endtask

   task automatic model_step();
      bit pre_v [D];
      bit taken [D];
      bit found;
      bit room;
      room  = (m_count() != D);
      pre_v = m_v;
      for (int i = 0; i < D; i++) taken[i] = 0;
      for (int k = 0; k < N; k++) begin
         exp_iv[k] = 1'b0;
         found = 0;
         if (iss_ready[k]) begin
            for (int i = 0; i < D; i++) begin
               if (!found && m_v[i] && m_r1[i] && m_r2[i] && !taken[i]) begin
                  found = 1; taken[i] = 1; exp_iv[k] = 1'b1;
                  exp_prd[k] = m_pd[i]; exp_prdv[k] = m_pdv[i]; exp_pl[k] = m_pl[i];
               end
            end
         end
      end
      if (flush) begin
         for (int i = 0; i < D; i++) m_v[i] = 0;
         exp_iv = '0;
         return;
      end
      for (int i = 0; i < D; i++) begin
         if (taken[i]) m_v[i] = 0;
         else if (m_v[i]) begin
            if (hit(m_p1[i])) m_r1[i] = 1;
            if (hit(m_p2[i])) m_r2[i] = 1;
         end
      end
      if (disp_valid && room) begin
         found = 0;
         for (int i = 0; i < D; i++) begin
            if (!found && !pre_v[i]) begin
               found = 1; m_v[i] = 1;
               m_p1[i] = disp_prs1; m_p2[i] = disp_prs2;
               m_r1[i] = disp_prs1_rdy || disp_prs1 == 0 || hit(disp_prs1);
               m_r2[i] = disp_prs2_rdy || disp_prs2 == 0 || hit(disp_prs2);
               m_pd[i] = disp_prd; m_pdv[i] = disp_prd_v; m_pl[i] = disp_payload;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("count", 64'(count), 64'(m_count()));
      chk("disp_ready", 64'(disp_ready), 64'(m_count() != D));
      chk("iss_valid", 64'(iss_valid), 64'(exp_iv));
      for (int k = 0; k < N; k++) begin
         if (exp_iv[k]) begin
            chk($sformatf("iss_prd[%0d]", k), 64'(iss_prd[k*W +: W]), 64'(exp_prd[k]));
            chk($sformatf("iss_prd_v[%0d]", k), 64'(iss_prd_v[k]), 64'(exp_prdv[k]));
            chk($sformatf("iss_payload[%0d]", k), 64'(iss_payload[k*P +: P]), 64'(exp_pl[k]));
         end
      end
   endtask

   task automatic disp(input logic [W-1:0] p1, input logic r1, input logic [W-1:0] p2,
                       input logic r2, input logic [W-1:0] pd, input logic [P-1:0] pl);
      disp_valid = 1; disp_prs1 = p1; disp_prs1_rdy = r1; disp_prs2 = p2; disp_prs2_rdy = r2;
      disp_prd = pd; disp_prd_v = 1; disp_payload = pl;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_all();
      disp_valid = 0; flush = 0; wake_v = '0;
   endtask

   initial begin
      rst_n = 0; flush = 0; disp_valid = 0; disp_prs1 = 0; disp_prs2 = 0; disp_prd = 0;
      disp_prs1_rdy = 0; disp_prs2_rdy = 0; disp_prd_v = 0; disp_payload = 0;
      wake_v = 0; wake_tag = 0; iss_ready = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", 64'(count), 0);
      chk("rst_disp_ready", 64'(disp_ready), 1);
      chk("rst_iss_valid", 64'(iss_valid), 0);
      chk("rst_iss_prd", 64'(iss_prd), 0);
      chk("rst_iss_prd_v", 64'(iss_prd_v), 0);
      chk("rst_iss_payload_zero", 64'(iss_payload == '0), 1);
      rst_n = 1;

      // fill to capacity, then a 17th request is refused
      for (int i = 0; i < D; i++) begin
         disp(0, 0, 0, 0, W'(i + 1), 32'hA000_0000 + i);
         tick();
      end
      chk("fill_count", 64'(count), 16);
      chk("fill_disp_ready", 64'(disp_ready), 0);
      disp(0, 0, 0, 0, 6'd63, 32'hBAD0_0000);
      tick();
      chk("overfill_count", 64'(count), 16);

      // full plus two grants: dispatch blocked, two slots freed
      iss_ready = 4'b0011;
      disp(0, 0, 0, 0, 6'd62, 32'hBAD0_0001);
      chk("full_free_ready", 64'(disp_ready), 0);
      tick();
      chk("full_free_count", 64'(count), 14);
      chk("full_free_iv", 64'(iss_valid), 64'(4'b0011));
      chk("full_free_p0", 64'(iss_payload[31:0]), 64'(32'hA000_0000));
      chk("full_free_p1", 64'(iss_payload[63:32]), 64'(32'hA000_0001));
      iss_ready = 0;
      disp(0, 0, 0, 0, 6'd7, 32'h0000_00C0);
      tick();
      chk("refill_count", 64'(count), 15);
      iss_ready = 4'b0001;
      tick();
      chk("refill_lowest_idx", 64'(iss_payload[31:0]), 64'(32'h0000_00C0));
      iss_ready = 4'b1111;
      repeat (5) tick();
      chk("drain_count", 64'(count), 0);

      // wake-up chain: A produces p5, B waits for it
      iss_ready = 0;
      disp(0, 1, 0, 1, 6'd5, 32'h0000_00AA);
      tick();
      iss_ready = 4'b0001;
      disp(6'd5, 0, 0, 0, 6'd12, 32'h0000_00BB);
      tick();
      chk("chain_a_issued", 64'(iss_payload[31:0]), 64'(32'h0000_00AA));
      wake_v = 4'b0001; wake_tag = 24'(6'd5);
      tick();
      chk("chain_b_not_yet", 64'(iss_valid), 0);
      tick();
      chk("chain_b_iv", 64'(iss_valid), 64'(4'b0001));
      chk("chain_b_payload", 64'(iss_payload[31:0]), 64'(32'h0000_00BB));

      // same-cycle dispatch wake on slot 2
      disp(6'd9, 0, 0, 1, 6'd3, 32'h0000_0099);
      wake_v = 4'b0100; wake_tag = 24'(6'd9) << 12;
      tick();
      chk("samecyc_edge1", 64'(iss_valid[0]), 0);
      tick();
      chk("samecyc_edge2", 64'(iss_valid[0]), 1);
      chk("samecyc_payload", 64'(iss_payload[31:0]), 64'(32'h0000_0099));

      // multi-port select: entries 1,3,4,7 ready, port 2 stalled
      iss_ready = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 1 || i == 3 || i == 4 || i == 7) disp(0, 0, 0, 1, W'(i + 16), 32'hD0 + i);
         else                                       disp(6'd40, 0, 0, 1, W'(i + 16), 32'hD0 + i);
         tick();
      end
      iss_ready = 4'b1011;
      tick();
      chk("mp_iv", 64'(iss_valid), 64'(4'b1011));
      chk("mp_p0", 64'(iss_payload[31:0]), 64'(32'hD1));
      chk("mp_p1", 64'(iss_payload[63:32]), 64'(32'hD3));
      chk("mp_p3", 64'(iss_payload[127:96]), 64'(32'hD4));
      chk("mp_count", 64'(count), 5);
      iss_ready = 4'b0001;
      tick();
      chk("mp_left_entry7", 64'(iss_payload[31:0]), 64'(32'hD7));
      iss_ready = 4'b1111;
      wake_v = 4'b1000; wake_tag = 24'(6'd40) << 18;
      repeat (3) tick();
      chk("mp_drain", 64'(count), 0);

      // flush beats same-cycle grant and dispatch
      iss_ready = 0;
      for (int i = 0; i < 6; i++) begin
         disp((i < 2) ? 6'd0 : 6'd50, 0, 0, 1, W'(i), 32'hF0 + i);
         tick();
      end
      iss_ready = 4'b0011; flush = 1;
      disp(0, 1, 0, 1, 6'd1, 32'hF9);
      tick();
      chk("flush_count", 64'(count), 0);
      chk("flush_iv", 64'(iss_valid), 0);

      // asynchronous reset while an issue is visible
      iss_ready = 4'b1111;
      disp(0, 1, 0, 1, 6'd2, 32'h0000_00EE);
      tick();
      tick();
      chk("pre_arst_iv", 64'(iss_valid[0]), 1);
      rst_n = 0;
      #1;
      model_reset();
      chk("arst_iv", 64'(iss_valid), 0);
      chk("arst_count", 64'(count), 0);
      @(posedge clk);
      #1;
      rst_n = 1;

      // random traffic with a small tag space so wake-ups hit often
      for (int c = 0; c < 400; c++) begin
         iss_ready = 4'($urandom);
         flush     = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) < 7)
            disp(6'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 6'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), 6'($urandom), $urandom);
         wake_v = 4'($urandom);
         for (int k = 0; k < N; k++) wake_tag[k*W +: W] = 6'($urandom_range(0, 7));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
